pc_redirect_ctrl: RTL and testbench
===================================

// Module: pc_redirect_ctrl
// PURPOSE
//  Fetch-stage PC register and next-PC selector for the 5-stage MIPS core.
//  Consumes the decode-stage branch outcome (taken flag from the branch comparator),
//  the jump info and the exception redirect, and produces the fetch PC.
//  Holds one pending redirect when decode resolves a branch/jump while fetch is
//  stalled, so the delay slot is never lost.
// PARAMETERS
//  RESET_PC   32'hBFC0_0000   PC loaded on reset
// PORTS
//  clk             in   1   core clock, rising edge
//  resetn          in   1   asynchronous active-low reset
//  stall_f         in   1   fetch stalled: hold pc_f
//  branch_d        in   1   decode holds a conditional branch (beq..bltzal)
//  taken_d         in   1   branch condition true; from the decode comparator
//  jump_d          in   1   decode holds j/jal
//  jr_d            in   1   decode holds jr/jalr
//  stall_d         in   1   decode stalled: its redirect inputs are not final
//  pcplus4_d       in   32  PC+4 of the decode instruction
//  imm_d           in   32  sign-extended 16-bit offset
//  instr_index_d   in   26  j/jal target field
//  rs_val_d        in   32  forwarded rs value (jr target)
//  flush_except    in   1   exception/eret redirect from the memory stage
//  except_pc       in   32  redirect address (0xBFC00380 or EPC)
//  pc_f            out  32  current fetch PC
//  pcplus4_f       out  32  pc_f + 4, modulo 2^32
//  adel_f          out  1   pc_f[1:0] != 0 (fetch address error)
//  pend_valid      out  1   a redirect is latched and not yet applied
// BEHAVIOUR
//  Reset (async, resetn=0): pc_f=RESET_PC, pend_valid=0, pend_target=0. Release is sampled on clk.
//  redir_d = !stall_d & ((branch_d & taken_d) | jump_d | jr_d).
//  Target, combinational, 32-bit wrap:
//   - branch: pcplus4_d + (imm_d<<2)
//   - jump:   {pcplus4_d[31:28], instr_index_d, 2'b00}
//   - jr:     rs_val_d
//  Exactly one of branch/jump/jr is active; the priority is jr > jump > branch.
//  The instruction in F while its branch is in D is the delay slot. The target therefore
//  replaces the PC that follows the delay slot.
//  FSM IDLE/PEND, one update per clk, priority top-down:
//   1 flush_except: pc_f<=except_pc regardless of stall_f. FSM->IDLE, pending cleared.
//   2 IDLE, redir_d, !stall_f: pc_f<=target (1-cycle latency), stay IDLE.
//   3 IDLE, redir_d, stall_f: pend_target<=target, ->PEND, pc_f held.
//   4 PEND, !stall_f: pc_f<=pend_target, ->IDLE (applied on the first unstalled edge).
//   5 PEND, stall_f: hold everything. A new redir_d is ignored (delay-slot branch is
//     architecturally unpredictable); the first pending target wins.
//   6 else: if !stall_f, pc_f<=pc_f+4; otherwise hold.
//  pend_valid = (state==PEND). adel_f and pcplus4_f are combinational from pc_f.
//  stall_d=1 suppresses redir_d (operands still forwarding). No redirect while decode stalls.
//  Wrap-around: 0xFFFFFFFC+4 -> 0x00000000. Branch arithmetic is also modulo 2^32.
//  A misaligned target is loaded as-is; adel_f flags it, and the exception logic flushes.
// STRUCTURE
//  defines.vh: RESET_PC value, EXCEPT_VECTOR 32'hBFC00380, PCSRC_* select encodings.
//  Sub-module pc_target_gen (combinational target + select). Top holds the PC register and FSM.
// TESTING
//  1 Reset: resetn=0 async mid-cycle -> pc_f=0xBFC00000 immediately, pend_valid=0.
//    Release, no stalls -> 0xBFC00004, 0xBFC00008 on successive edges.
//  2 Taken beq: pcplus4_d=0xBFC00008, imm_d=3, taken_d=1 -> next pc_f=0xBFC00014.
//    Same with taken_d=0 -> pc_f+4.
//  3 Branch under fetch stall: redir_d with stall_f=1 for 3 cycles -> pend_valid=1, pc_f held.
//    Then stall_f=0 -> pc_f=target on the next edge, pend_valid=0.
//  4 Flush wins: PEND plus flush_except=1, except_pc=0xBFC00380, stall_f=1 -> pc_f=0xBFC00380,
//    pend_valid=0, old target never appears.
//  5 jr to rs_val_d=0x80000002 -> pc_f=0x80000002, adel_f=1.
//    j with pcplus4_d=0x9000_0000, index=0x1 -> pc_f=0x90000004.
//  6 Wrap: pc_f=0xFFFFFFFC, no stall -> pc_f=0x00000000.
//    Plus redirect with stall_d=1 -> ignored, pc_f+4.

Source files
------------

// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared constants and types for the fetch-stage PC redirect controller.
package pc_redirect_ctrl_pkg;

    localparam logic [31:0] RESET_PC_DEF  = 32'hBFC0_0000;
    localparam logic [31:0] EXCEPT_VECTOR = 32'hBFC0_0380;

    // Which target source the decode stage selected.
    typedef enum logic [1:0] {
        PCSRC_BRANCH = 2'd0,
        PCSRC_JUMP   = 2'd1,
        PCSRC_JR     = 2'd2,
        PCSRC_NONE   = 2'd3
    } pcsrc_e;

    // Redirect FSM: IDLE, or holding one redirect that arrived during a fetch stall.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } redir_state_e;

    // Sequential fetch address; wraps modulo 2^32.
    function automatic logic [31:0] pc_add4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/pc_redirect_ctrl_pc_target_gen.sv
// Combinational redirect decision and target address for the decode-stage
// branch/jump/jr. Priority jr > jump > branch; all arithmetic wraps at 32 bits.
module pc_target_gen
    import pc_redirect_ctrl_pkg::*;
(
    input  logic        branch_i,
    input  logic        taken_i,
    input  logic        jump_i,
    input  logic        jr_i,
    input  logic        stall_d_i,
    input  logic [31:0] pcplus4_d_i,
    input  logic [31:0] imm_d_i,
    input  logic [25:0] instr_index_i,
    input  logic [31:0] rs_val_i,
    output logic        redir_o,
    output logic [31:0] target_o
);

    pcsrc_e sel_s;

    // Select the target source; a stalled decode stage never redirects.
    always_comb begin
        sel_s = PCSRC_NONE;
        if (stall_d_i) begin
            sel_s = PCSRC_NONE;
        end else if (jr_i) begin
            sel_s = PCSRC_JR;
        end else if (jump_i) begin
            sel_s = PCSRC_JUMP;
        end else if (branch_i && taken_i) begin
            sel_s = PCSRC_BRANCH;
        end else begin
            sel_s = PCSRC_NONE;
        end
    end

    // Form the target for the selected source.
    always_comb begin
        target_o = 32'h0000_0000;
        redir_o  = 1'b0;
        case (sel_s)
            PCSRC_BRANCH: begin
                target_o = pcplus4_d_i + {imm_d_i[29:0], 2'b00};
                redir_o  = 1'b1;
            end
            PCSRC_JUMP: begin
                target_o = {pcplus4_d_i[31:28], instr_index_i, 2'b00};
                redir_o  = 1'b1;
            end
            PCSRC_JR: begin
                target_o = rs_val_i;
                redir_o  = 1'b1;
            end
            default: begin
                target_o = 32'h0000_0000;
                redir_o  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch-stage PC register with a one-entry pending-redirect FSM so a branch
// resolved while fetch is stalled still lands after its delay slot.
module pc_redirect_ctrl
    import pc_redirect_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stall_f,
    input  logic        branch_d,
    input  logic        taken_d,
    input  logic        jump_d,
    input  logic        jr_d,
    input  logic        stall_d,
    input  logic [31:0] pcplus4_d,
    input  logic [31:0] imm_d,
    input  logic [25:0] instr_index_d,
    input  logic [31:0] rs_val_d,
    input  logic        flush_except,
    input  logic [31:0] except_pc,
    output logic [31:0] pc_f,
    output logic [31:0] pcplus4_f,
    output logic        adel_f,
    output logic        pend_valid
);

    redir_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pend_target_q, pend_target_d;
    logic         redir_s;
    logic [31:0]  target_s;

    pc_target_gen u_target_gen (
        .branch_i      (branch_d),
        .taken_i       (taken_d),
        .jump_i        (jump_d),
        .jr_i          (jr_d),
        .stall_d_i     (stall_d),
        .pcplus4_d_i   (pcplus4_d),
        .imm_d_i       (imm_d),
        .instr_index_i (instr_index_d),
        .rs_val_i      (rs_val_d),
        .redir_o       (redir_s),
        .target_o      (target_s)
    );

    // Next PC / pending target / state; exception flush overrides everything.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_target_d = pend_target_q;
        if (flush_except) begin
            pc_d          = except_pc;
            state_d       = ST_IDLE;
            pend_target_d = 32'h0000_0000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (redir_s && !stall_f) begin
                        pc_d = target_s;
                    end else if (redir_s) begin
                        pend_target_d = target_s;
                        state_d       = ST_PEND;
                    end else if (!stall_f) begin
                        pc_d = pc_add4(pc_q);
                    end else begin
                        pc_d = pc_q;
                    end
                end
                ST_PEND: begin
                    // A redirect arriving now is from the delay slot and is dropped.
                    if (!stall_f) begin
                        pc_d    = pend_target_q;
                        state_d = ST_IDLE;
                    end else begin
                        pc_d = pc_q;
                    end
                end
                default: begin
                    state_d       = ST_IDLE;
                    pc_d          = pc_q;
                    pend_target_d = 32'h0000_0000;
                end
            endcase
        end
    end

    // PC register, pending target and FSM state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            pend_target_q <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign pc_f       = pc_q;
    assign pcplus4_f  = pc_add4(pc_q);
    assign adel_f     = (pc_q[1:0] != 2'b00);
    assign pend_valid = (state_q == ST_PEND);

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl with hand-computed expected PCs.
module tb_pc_redirect_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        stall_f, branch_d, taken_d, jump_d, jr_d, stall_d, flush_except;
    logic [31:0] pcplus4_d, imm_d, rs_val_d, except_pc;
    logic [25:0] instr_index_d;
    logic [31:0] pc_f, pcplus4_f;
    logic        adel_f, pend_valid;

    int checks = 0;
    int errors = 0;

    pc_redirect_ctrl dut (
        .clk           (clk),
        .resetn        (resetn),
        .stall_f       (stall_f),
        .branch_d      (branch_d),
        .taken_d       (taken_d),
        .jump_d        (jump_d),
        .jr_d          (jr_d),
        .stall_d       (stall_d),
        .pcplus4_d     (pcplus4_d),
        .imm_d         (imm_d),
        .instr_index_d (instr_index_d),
        .rs_val_d      (rs_val_d),
        .flush_except  (flush_except),
        .except_pc     (except_pc),
        .pc_f          (pc_f),
        .pcplus4_f     (pcplus4_f),
        .adel_f        (adel_f),
        .pend_valid    (pend_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        branch_d = 1'b0; taken_d = 1'b0; jump_d = 1'b0; jr_d = 1'b0;
        stall_d = 1'b0; stall_f = 1'b0; flush_except = 1'b0;
        pcplus4_d = 32'h0; imm_d = 32'h0; rs_val_d = 32'h0; except_pc = 32'h0;
        instr_index_d = 26'h0;
    endtask

    initial begin
        idle_inputs();
        resetn = 1'b1;
        // 1: async reset mid-cycle, then sequential fetch
        #2 resetn = 1'b0;
        #1;
        check("rst_pc", pc_f, 32'hBFC0_0000);
        check("rst_pend", {31'd0, pend_valid}, 32'd0);
        check("rst_pcplus4", pcplus4_f, 32'hBFC0_0004);
        check("rst_adel", {31'd0, adel_f}, 32'd0);
        @(negedge clk); @(negedge clk);
        resetn = 1'b1;
        tick(); check("seq1", pc_f, 32'hBFC0_0004);
        tick(); check("seq2", pc_f, 32'hBFC0_0008);

        // 2: taken / not-taken beq
        branch_d = 1'b1; taken_d = 1'b1; pcplus4_d = 32'hBFC0_0008; imm_d = 32'd3;
        tick(); check("beq_taken", pc_f, 32'hBFC0_0014);
        taken_d = 1'b0;
        tick(); check("beq_not_taken", pc_f, 32'hBFC0_0018);

        // 3: backward branch under fetch stall, delay-slot redirect ignored
        taken_d = 1'b1; pcplus4_d = 32'h0000_1000; imm_d = 32'hFFFF_FFFF; stall_f = 1'b1;
        tick(); check("pend_set", {31'd0, pend_valid}, 32'd1);
        check("pend_pc_hold1", pc_f, 32'hBFC0_0018);
        idle_inputs(); stall_f = 1'b1;
        tick(); check("pend_pc_hold2", pc_f, 32'hBFC0_0018);
        jr_d = 1'b1; rs_val_d = 32'h1234_5678;
        tick(); check("pend_pc_hold3", pc_f, 32'hBFC0_0018);
        check("pend_still", {31'd0, pend_valid}, 32'd1);
        jr_d = 1'b0; stall_f = 1'b0;
        tick(); check("pend_apply", pc_f, 32'h0000_0FFC);
        check("pend_clear", {31'd0, pend_valid}, 32'd0);
        tick(); check("after_pend", pc_f, 32'h0000_1000);

        // 4: flush beats a pending jump
        jump_d = 1'b1; pcplus4_d = 32'h2000_0000; instr_index_d = 26'h10; stall_f = 1'b1;
        tick(); check("pend2_set", {31'd0, pend_valid}, 32'd1);
        jump_d = 1'b0; flush_except = 1'b1; except_pc = 32'hBFC0_0380;
        tick(); check("flush_pc", pc_f, 32'hBFC0_0380);
        check("flush_pend", {31'd0, pend_valid}, 32'd0);
        flush_except = 1'b0;
        tick(); check("flush_hold", pc_f, 32'hBFC0_0380);
        stall_f = 1'b0;
        tick(); check("flush_no_old", pc_f, 32'hBFC0_0384);

        // 5: jr misaligned, j, priority
        jr_d = 1'b1; rs_val_d = 32'h8000_0002;
        tick(); check("jr_pc", pc_f, 32'h8000_0002);
        check("jr_adel", {31'd0, adel_f}, 32'd1);
        check("jr_pcplus4", pcplus4_f, 32'h8000_0006);
        jr_d = 1'b0; jump_d = 1'b1; pcplus4_d = 32'h9000_0000; instr_index_d = 26'h1;
        tick(); check("j_pc", pc_f, 32'h9000_0004);
        check("j_adel", {31'd0, adel_f}, 32'd0);
        jr_d = 1'b1; rs_val_d = 32'h1234_5678; branch_d = 1'b1; taken_d = 1'b1; imm_d = 32'd8;
        tick(); check("prio_jr", pc_f, 32'h1234_5678);
        jr_d = 1'b0; pcplus4_d = 32'h4000_0000; instr_index_d = 26'h3FF_FFFF;
        tick(); check("prio_jump", pc_f, 32'h4FFF_FFFC);

        // 6: wrap-around and stall_d suppression
        idle_inputs();
        jr_d = 1'b1; rs_val_d = 32'hFFFF_FFFC;
        tick(); check("wrap_pre", pc_f, 32'hFFFF_FFFC);
        check("wrap_pcplus4", pcplus4_f, 32'h0000_0000);
        jr_d = 1'b0;
        tick(); check("wrap_pc", pc_f, 32'h0000_0000);
        jr_d = 1'b1; rs_val_d = 32'h5555_5554; stall_d = 1'b1;
        tick(); check("stall_d_ignored", pc_f, 32'h0000_0004);
        stall_f = 1'b1;
        tick(); check("stall_d_no_pend", {31'd0, pend_valid}, 32'd0);
        check("stall_d_hold", pc_f, 32'h0000_0004);
        idle_inputs();
        branch_d = 1'b1; taken_d = 1'b1; pcplus4_d = 32'hFFFF_FFF0; imm_d = 32'h10;
        tick(); check("branch_wrap", pc_f, 32'h0000_0030);
        idle_inputs();

        // async reset with state away from reset value
        #3 resetn = 1'b0;
        #1;
        check("rst2_pc", pc_f, 32'hBFC0_0000);
        check("rst2_pend", {31'd0, pend_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
